// File: rtl/uram_sdp_stream_reader.sv
// uram_sdp_stream_reader
//   Read-side master for an UltraRAM simple-dual-port block. Accepts
//   (addr,len) burst commands, issues one RAM read per cycle on the read port
//   and converts the fixed NBPIPE+2 cycle read latency into a valid/ready
//   stream. Reads are only issued while the output FIFO is guaranteed to have
//   room for them (FIFO entries + reads in flight < FDEPTH), so no read beat
//   is ever dropped under backpressure.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_addr              burst start address (wraps modulo 2**AWIDTH)
//   cmd_len               beats to read, 0..2**AWIDTH (0 is a no-op)
//   ram_mem_en            RAM read enable, one pulse per issued read
//   ram_addrb             RAM read address (holds its value between reads)
//   ram_regceb            RAM output register enable, 1 once out of reset
//   ram_doutb             RAM read data
//   m_valid/m_ready       output stream handshake
//   m_data, m_last        stream data and end-of-burst flag
//   busy                  commands, reads or queued beats outstanding
module uram_sdp_stream_reader #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 72,
  parameter int NBPIPE = 3,
  parameter int FDEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [AWIDTH:0]   cmd_len,
  output logic              ram_mem_en,
  output logic [AWIDTH-1:0] ram_addrb,
  output logic              ram_regceb,
  input  logic [DWIDTH-1:0] ram_doutb,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic              busy
);

  localparam int TDEPTH = NBPIPE + 2;
  localparam int PW     = $clog2(FDEPTH);
  localparam int CW     = PW + 1;
  localparam logic [CW:0]     OCC_LIMIT  = (CW+1)'(FDEPTH);
  localparam logic [CW-1:0]   ARR_FULL   = CW'(FDEPTH);
  localparam logic [AWIDTH:0] REMAIN_ONE = (AWIDTH+1)'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [AWIDTH:0]     remain_q, remain_d;
  logic                rst_done_q;
  logic [TDEPTH-1:0]   tag_valid_q, tag_last_q;
  logic [CW-1:0]       inflight_q, arr_count_q, fifo_count;
  logic [CW:0]         occ;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [DWIDTH:0]     arr_q [FDEPTH];
  logic                issue, final_issue, cmd_fire;
  logic                push, push_last, out_load, arr_pop, arr_push, bypass;

  // Occupancy counts the output register as a FIFO entry; all terms are
  // registered so a pop in this cycle does not lend credit to this cycle.
  assign fifo_count = arr_count_q + CW'(m_valid);
  assign occ        = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign push       = tag_valid_q[TDEPTH-1];
  assign push_last  = tag_last_q[TDEPTH-1];
  assign ram_regceb = rst_done_q;
  assign busy       = (state_q != IDLE) || (inflight_q != '0) || (fifo_count != '0);

  // Next-state logic. The command port also opens on the cycle that issues
  // a burst's final read, so consecutive bursts chain with no lost issue slot.
  // A command loaded in that cycle overrides the end-of-burst return to IDLE.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remain_d    = remain_q;
    issue       = (state_q == RUN) && (occ < OCC_LIMIT);
    final_issue = issue && (remain_q == REMAIN_ONE);
    cmd_ready   = rst_done_q && ((state_q == IDLE) || final_issue);
    cmd_fire    = cmd_valid && cmd_ready;
    if (issue) begin
      cur_addr_d = cur_addr_q + AWIDTH'(1);
      remain_d   = remain_q - REMAIN_ONE;
      if (final_issue) begin
        state_d = IDLE;
      end
    end
    if (cmd_fire && (cmd_len != '0)) begin
      state_d    = RUN;
      cur_addr_d = cmd_addr;
      remain_d   = cmd_len;
    end
  end

  // State register, read port and tag pipe. A tag enters the pipe on the
  // same edge as its read is presented to the RAM; when it reaches the end
  // of the pipe, ram_doutb carries that read's data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remain_q    <= '0;
      rst_done_q  <= 1'b0;
      ram_mem_en  <= 1'b0;
      ram_addrb   <= '0;
      tag_valid_q <= '0;
      tag_last_q  <= '0;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remain_q    <= remain_d;
      rst_done_q  <= 1'b1;
      ram_mem_en  <= issue;
      if (issue) begin
        ram_addrb <= cur_addr_q;
      end
      tag_valid_q <= {tag_valid_q[TDEPTH-2:0], issue};
      tag_last_q  <= {tag_last_q[TDEPTH-2:0], final_issue};
      if (issue && !push) begin
        inflight_q <= inflight_q + CW'(1);
      end else if (!issue && push) begin
        inflight_q <= inflight_q - CW'(1);
      end
    end
  end

  // Output FIFO: storage array in front of a registered output stage. A push
  // into an empty FIFO goes straight to the output stage when it can load.
  always_comb begin
    out_load = !m_valid || m_ready;
    arr_pop  = out_load && (arr_count_q != '0);
    bypass   = out_load && (arr_count_q == '0) && push;
    arr_push = push && !bypass;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arr_count_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
    end else begin
      if (arr_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (arr_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (arr_push && !arr_pop) begin
        arr_count_q <= arr_count_q + CW'(1);
      end else if (!arr_push && arr_pop) begin
        arr_count_q <= arr_count_q - CW'(1);
      end
      if (out_load) begin
        m_valid <= arr_pop || bypass;
        if (arr_pop) begin
          {m_last, m_data} <= arr_q[rd_ptr_q];
        end else if (bypass) begin
          m_data <= ram_doutb;
          m_last <= push_last;
        end
      end
    end
  end

  // Storage needs no reset: the cleared count makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (arr_push) begin
      arr_q[wr_ptr_q] <= {push_last, ram_doutb};
    end
  end

  a_credit : assert property (@(posedge clk) disable iff (rst) occ <= OCC_LIMIT);
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
                                   !(arr_push && (arr_count_q == ARR_FULL)));

endmodule
